// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types and constants for the Wishbone shared-port
//                arbiter (FSM state encoding, grant owner, byte-select mask).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // Wide enough for any supported data width; users slice to SEL_WIDTH.
    localparam logic [63:0] ALL_SEL = '1;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_timeout_ctr
//  Description : Bus watchdog cycle counter. Cleared while the arbiter is not
//                on the bus, counts BUS cycles without acknowledge, and flags
//                the last allowed cycle so the arbiter can abandon the access
//                at the following edge.
//  Ports       : sys_clk, rst_n (async, active-low)
//                clear   - hold count at zero
//                enable  - advance count by one
//                expired - current cycle is the TIMEOUT_CYCLES-th BUS cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count starts at zero in the first BUS cycle, so TIMEOUT_CYCLES-1 marks
    // the final cycle the slave is given.
    assign expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule : wb_arb_timeout_ctr
`default_nettype wire

// File: rtl/wb_shared_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_shared_port_arbiter
//  Description : Shares one Wishbone classic master port between the core's
//                instruction-fetch and data requesters. Round-robin grant on
//                contention, a single transaction in flight, registered
//                one-cycle ready pulse with read data to the winner.
//  Ports       : sys_clk, rst_n            clock, async active-low reset
//                i_req/i_addr/i_ready/i_rdata/i_err           fetch side
//                d_req/d_we/d_sel/d_addr/d_wdata/
//                d_ready/d_rdata/d_err                        data side
//                core_cyc/stb/we/sel/addr/data_out/data_in/ack Wishbone master
//  Options     : ARB_TIMEOUT_EN - bus watchdog; after TIMEOUT_CYCLES BUS
//                cycles without ack the access ends with TIMEOUT_DATA and err.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_shared_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
    localparam int                   SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    // instruction fetch requester
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,
    // data requester
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [SEL_WIDTH-1:0]  d_sel,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    // shared Wishbone master port
    output logic                  core_cyc,
    output logic                  core_stb,
    output logic                  core_we,
    output logic [SEL_WIDTH-1:0]  core_sel,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    input  logic                  core_ack
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    grant_t     r_last_grant;
    grant_t     r_owner;
    grant_t     w_grant;
    logic       w_start;
    logic       w_bus_ack;
    logic       w_timeout;

    logic                  r_we;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    // Acks arriving outside BUS are meaningless and must not disturb state.
    assign w_bus_ack = (r_state == BUS) && core_ack;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_grant      = GRANT_INSTR;
        case (r_state)
            IDLE: begin
                if (i_req && d_req) begin
                    w_start = 1'b1;
                    // Alternate on contention: the port that did not win last.
                    w_grant = (r_last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
                end else if (d_req) begin
                    w_start = 1'b1;
                    w_grant = GRANT_DATA;
                end else if (i_req) begin
                    w_start = 1'b1;
                    w_grant = GRANT_INSTR;
                end
                if (w_start) begin
                    w_next_state = BUS;
                end
            end
            BUS: begin
                if (core_ack || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Payload latch and response data capture
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_INSTR;
            r_owner      <= GRANT_INSTR;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_start) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == GRANT_DATA) begin
                    r_we    <= d_we;
                    r_sel   <= d_sel;
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_sel   <= ALL_SEL[SEL_WIDTH-1:0];
                    r_addr  <= i_addr;
                    r_wdata <= '0;
                end
            end

            // Ack takes priority over a coincident watchdog expiry.
            if (w_bus_ack) begin
                if (r_owner == GRANT_DATA) begin
                    r_d_rdata <= core_data_in;
                end else begin
                    r_i_rdata <= core_data_in;
                end
            end else if (w_timeout) begin
                if (r_owner == GRANT_DATA) begin
                    r_d_rdata <= TIMEOUT_DATA;
                end else begin
                    r_i_rdata <= TIMEOUT_DATA;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional bus watchdog
    // ------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    logic w_expired;
    logic r_err;

    wb_arb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clear   (r_state != BUS),
        .enable  ((r_state == BUS) && !core_ack),
        .expired (w_expired)
    );

    assign w_timeout = (r_state == BUS) && !core_ack && w_expired;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_bus_ack) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign i_err = i_ready && r_err;
    assign d_err = d_ready && r_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
    assign i_err        = 1'b0;
    assign d_err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // cyc/stb decode straight from the state register so an asynchronous
    // reset removes them without waiting for a clock edge.
    assign core_cyc      = (r_state == BUS);
    assign core_stb      = (r_state == BUS);
    assign core_we       = r_we;
    assign core_sel      = r_sel;
    assign core_addr     = r_addr;
    assign core_data_out = r_wdata;

    assign i_ready = (r_state == RESP) && (r_owner == GRANT_INSTR);
    assign d_ready = (r_state == RESP) && (r_owner == GRANT_DATA);
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule : wb_shared_port_arbiter
`default_nettype wire

// File: tb/tb_wb_shared_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wb_shared_port_arbiter
//  Description : Directed self-checking bench for wb_shared_port_arbiter.
//                Inputs and the slave model change on the falling edge;
//                outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_shared_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          i_req   = 1'b0;
    logic [AW-1:0] i_addr  = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          i_err;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [SW-1:0] d_sel   = '0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          core_cyc;
    logic          core_stb;
    logic          core_we;
    logic [SW-1:0] core_sel;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data_out;
    logic [DW-1:0] core_data_in = '0;
    logic          core_ack     = 1'b0;

    always #5 sys_clk = ~sys_clk;

    wb_shared_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_ready       (i_ready),
        .i_rdata       (i_rdata),
        .i_err         (i_err),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_sel         (d_sel),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_ready       (d_ready),
        .d_rdata       (d_rdata),
        .d_err         (d_err),
        .core_cyc      (core_cyc),
        .core_stb      (core_stb),
        .core_we       (core_we),
        .core_sel      (core_sel),
        .core_addr     (core_addr),
        .core_data_out (core_data_out),
        .core_data_in  (core_data_in),
        .core_ack      (core_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave: acks in BUS cycle number ack_wait (0 = first), or never.
    int            ack_wait    = 0;
    bit            slave_never = 1'b0;
    logic [DW-1:0] slave_data  = '0;
    int            wcnt        = 0;

    initial forever begin
        @(negedge sys_clk);
        if (core_cyc && !slave_never) begin
            core_ack     = (wcnt == ack_wait);
            core_data_in = slave_data;
            wcnt++;
        end else begin
            core_ack = 1'b0;
            wcnt     = 0;
        end
    end

    // Records the address of every transaction at its first BUS cycle.
    logic [AW-1:0] grant_q[$];
    logic          prev_cyc = 1'b0;

    initial forever begin
        @(negedge sys_clk);
        if (core_cyc && !prev_cyc) grant_q.push_back(core_addr);
        prev_cyc = core_cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1);
    end

    initial begin
        bit            seen;
        int            nbus;
        logic [AW-1:0] exp_q [4];
        logic [AW-1:0] got;

        // ---------------- reset state ----------------
        repeat (2) @(negedge sys_clk);
        check_eq("rst_bus", {core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out}, '0);
        check_eq("rst_flags", {i_ready, d_ready, i_err, d_err}, '0);
        check_eq("rst_rdata", {i_rdata, d_rdata}, '0);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // ---------------- T1: zero-wait instruction fetch ----------------
        i_req = 1'b1; i_addr = 32'h0000_0100; ack_wait = 0; slave_data = 32'h0000_0013;
        @(negedge sys_clk);
        check_eq("t1_bus", {core_cyc, core_stb, core_we, core_sel, core_addr},
                 {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100});
        check_eq("t1_no_early_ready", i_ready, 1'b0);
        @(negedge sys_clk);
        check_eq("t1_i_ready", i_ready, 1'b1);
        check_eq("t1_i_rdata", i_rdata, 32'h0000_0013);
        check_eq("t1_others", {d_ready, i_err, core_cyc}, 3'b000);
        i_req = 1'b0;
        @(negedge sys_clk);
        check_eq("t1_pulse_end", i_ready, 1'b0);
        check_eq("t1_rdata_hold", i_rdata, 32'h0000_0013);

        // ---------------- T2: data write with 4 wait states ----------------
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h8000_0004;
        d_wdata = 32'h1234_ABCD; ack_wait = 4; slave_data = 32'hCAFE_F00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            check_eq($sformatf("t2_bus_ctl%0d", k), {core_cyc, core_stb, core_we, core_sel, core_addr},
                     {1'b1, 1'b1, 1'b1, 4'b0011, 32'h8000_0004});
            check_eq($sformatf("t2_bus_dat%0d", k), core_data_out, 32'h1234_ABCD);
            check_eq($sformatf("t2_no_ready%0d", k), {i_ready, d_ready}, 2'b00);
        end
        @(negedge sys_clk);
        check_eq("t2_d_ready", {d_ready, i_ready, d_err, core_cyc}, 4'b1000);
        check_eq("t2_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge sys_clk);
        check_eq("t2_pulse_end", d_ready, 1'b0);

        // ---------------- T3: contention right after reset ----------------
        rst_n = 1'b0;
        @(negedge sys_clk);
        grant_q.delete();
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h0000_0200;
        ack_wait = 0; slave_data = 32'h0000_00AA;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge sys_clk);
            if (grant_q.size() >= 4 && (i_ready || d_ready)) seen = 1'b1;
        end
        i_req = 1'b0; d_req = 1'b0;
        check_eq("t3_done", seen, 1'b1);
        check_eq("t3_grant_count", grant_q.size(), 4);
        exp_q = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0200, 32'h0000_0100};
        for (int k = 0; k < 4; k++) begin
            got = (k < grant_q.size()) ? grant_q[k] : 32'hFFFF_FFFF;
            check_eq($sformatf("t3_grant%0d", k), got, exp_q[k]);
        end
        @(negedge sys_clk);

        // ---------------- T4: reset during BUS ----------------
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h0000_0300;
        ack_wait = 3; slave_data = 32'h3030_3030;
        @(negedge sys_clk);
        check_eq("t4_bus_up", core_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_eq("t4_async_drop", {core_cyc, core_stb}, 2'b00);
        seen = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            if (i_ready || d_ready) seen = 1'b1;
        end
        check_eq("t4_no_ready", seen, 1'b0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check_eq("t4_rearb", {core_cyc, core_addr}, {1'b1, 32'h0000_0300});
        nbus = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge sys_clk);
            nbus++;
            if (d_ready) seen = 1'b1;
        end
        check_eq("t4_latency", nbus, 4);
        check_eq("t4_d_rdata", {d_err, d_rdata}, {1'b0, 32'h3030_3030});
        d_req = 1'b0;
        @(negedge sys_clk);

`ifdef ARB_TIMEOUT_EN
        // ---------------- T5: watchdog expiry, slave never acks ----------------
        slave_never = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        nbus = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge sys_clk);
            if (core_cyc) nbus++;
            if (d_ready) seen = 1'b1;
        end
        check_eq("t5_bus_cycles", nbus, 8);
        check_eq("t5_resp", {d_ready, d_err, core_cyc}, 3'b110);
        check_eq("t5_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        @(negedge sys_clk);

        // ---------------- T6: ack on the expiry cycle wins ----------------
        slave_never = 1'b0; ack_wait = 7; slave_data = 32'h5555_5555;
        d_req = 1'b1;
        nbus = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge sys_clk);
            if (core_cyc) nbus++;
            if (d_ready) seen = 1'b1;
        end
        check_eq("t6_bus_cycles", nbus, 8);
        check_eq("t6_resp", {d_ready, d_err, i_err}, 3'b100);
        check_eq("t6_rdata", d_rdata, 32'h5555_5555);
        d_req = 1'b0;
        @(negedge sys_clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_shared_port_arbiter
`default_nettype wire
